// File: rtl/tag_tracker_pkg.sv
// Shared tag-space parameters and helpers for rename, issue and retire.
// TAGS also sets the done_flags width seen by every issue buffer.
package tag_tracker_pkg;

    localparam int TAGS      = 30;
    localparam int TAG_W     = 5;
    localparam int ARCH_TAGS = 5;
    localparam int FREE_INIT = TAGS - ARCH_TAGS;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   cnt_t;
    typedef logic [TAGS-1:0]  flags_t;

    // Depth is not a power of two, so wrap on an explicit compare.
    function automatic tag_t ptr_inc(input tag_t p);
        return (p == tag_t'(TAGS - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic tag_ok(input tag_t t);
        return int'(t) < TAGS;
    endfunction

    function automatic flags_t tag_mask(input tag_t t);
        return flags_t'(1) << t;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Circular free-tag FIFO, depth TAGS, preloaded at reset.
// Ports: i_clk/i_rst, i_push/i_push_tag (tail write), i_pop (head
// advance, ignored when empty), o_head_tag, o_count.
module tag_fifo
    import tag_tracker_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  tag_t i_push_tag,
    input  logic i_pop,
    output tag_t o_head_tag,
    output cnt_t o_count
);

    tag_t r_mem [TAGS];
    tag_t r_head;
    tag_t r_tail;
    cnt_t r_count;
    logic w_pop;

    // Pop is blocked when empty, so a tag pushed into an empty
    // list only reaches the head output on the following cycle.
    assign w_pop      = i_pop & (r_count != '0);
    assign o_head_tag = r_mem[r_head];
    assign o_count    = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < TAGS; i++) begin
                r_mem[i] <= (i < FREE_INIT) ? tag_t'(i + ARCH_TAGS) : '0;
            end
            r_head  <= '0;
            r_tail  <= tag_t'(FREE_INIT);
            r_count <= cnt_t'(FREE_INIT);
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_tag;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            unique case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tag_tracker.sv
// Physical-tag allocator and completion scoreboard (done_flags).
// Ports: alloc handshake (o_alloc_tag/o_alloc_valid/i_alloc_ready),
// completion bus (i_cmpl_*), retire free (i_free_*), o_free_count,
// o_done_flags. All outputs come straight from registered state.
module tag_tracker
    import tag_tracker_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    output logic [TAG_W-1:0]   o_alloc_tag,
    output logic               o_alloc_valid,
    input  logic               i_alloc_ready,
    input  logic               i_cmpl_valid,
    input  logic [TAG_W-1:0]   i_cmpl_tag,
    input  logic               i_free_valid,
    input  logic [TAG_W-1:0]   i_free_tag,
    output logic [TAG_W:0]     o_free_count,
    output logic [TAGS-1:0]    o_done_flags
);

    flags_t r_done;
    flags_t w_done_nxt;
    tag_t   w_head_tag;
    cnt_t   w_count;
    logic   w_alloc;
    logic   w_push;
    logic   w_cmpl;

    // Out-of-range tags are dropped: no push, no flag write.
    assign w_push  = i_free_valid & tag_ok(i_free_tag);
    assign w_cmpl  = i_cmpl_valid & tag_ok(i_cmpl_tag);
    assign w_alloc = o_alloc_valid & i_alloc_ready;

    tag_fifo u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_push_tag (i_free_tag),
        .i_pop      (w_alloc),
        .o_head_tag (w_head_tag),
        .o_count    (w_count)
    );

    assign o_alloc_tag   = w_head_tag;
    assign o_alloc_valid = (w_count != '0);
    assign o_free_count  = w_count;
    assign o_done_flags  = r_done;

    // Clear applied after set: allocation wins on a same-tag clash.
    always_comb begin
        w_done_nxt = r_done;
        if (w_cmpl) begin
            w_done_nxt = w_done_nxt | tag_mask(i_cmpl_tag);
        end
        if (w_alloc) begin
            w_done_nxt = w_done_nxt & ~tag_mask(w_head_tag);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done <= '1;
        end else begin
            r_done <= w_done_nxt;
        end
    end

`ifndef SYNTHESIS
    // Shadow membership of the free list, used only to flag
    // double frees.
    flags_t r_sh_in_list;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_in_list <= '1 << ARCH_TAGS;
        end else begin
            r_sh_in_list <= (r_sh_in_list
                & ~(w_alloc ? tag_mask(w_head_tag) : '0))
                | (w_push ? tag_mask(i_free_tag) : '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (i_free_valid) begin
                assert (tag_ok(i_free_tag))
                else $error("free_tag out of range");
                assert (int'(w_count) < TAGS)
                else $error("free into full list");
                assert (!(tag_ok(i_free_tag) &&
                          r_sh_in_list[i_free_tag]))
                else $error("tag freed twice");
            end
            if (i_cmpl_valid) begin
                assert (tag_ok(i_cmpl_tag))
                else $error("cmpl_tag out of range");
                assert (!(w_alloc && i_cmpl_tag == w_head_tag))
                else $error("cmpl and alloc of same tag");
            end
        end
    end
`endif

endmodule

// File: tb/tb_tag_tracker.sv
// Directed self-checking bench for tag_tracker.
// Drives inputs between edges and samples #1 after each rising edge.
module tb_tag_tracker;
    import tag_tracker_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4:0]      alloc_tag;
    logic            alloc_valid;
    logic            alloc_ready = 1'b0;
    logic            cmpl_valid = 1'b0;
    logic [4:0]      cmpl_tag = '0;
    logic            free_valid = 1'b0;
    logic [4:0]      free_tag = '0;
    logic [5:0]      free_count;
    logic [29:0]     done_flags;

    int n_checks = 0;
    int n_fail   = 0;

    tag_tracker dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_alloc_tag   (alloc_tag),
        .o_alloc_valid (alloc_valid),
        .i_alloc_ready (alloc_ready),
        .i_cmpl_valid  (cmpl_valid),
        .i_cmpl_tag    (cmpl_tag),
        .i_free_valid  (free_valid),
        .i_free_tag    (free_tag),
        .o_free_count  (free_count),
        .o_done_flags  (done_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_tag"},   32'(alloc_tag),   32'd5);
        chk({pfx, "_valid"}, 32'(alloc_valid), 32'd1);
        chk({pfx, "_count"}, 32'(free_count),  32'd25);
        chk({pfx, "_done"},  32'(done_flags),  32'h3FFFFFFF);
    endtask

    logic [4:0]  list_q[$];
    logic [4:0]  out_q[$];
    logic [29:0] exp_done;
    logic [4:0]  ft;
    logic [4:0]  hd;
    int          idx;

    initial begin
        step();
        step();
        rst = 1'b0;
        chk_reset("rst");
        step();
        chk_reset("hold");

        // Drain the whole list in order.
        alloc_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            chk("drain_tag", 32'(alloc_tag), 32'(i + 5));
            step();
        end
        alloc_ready = 1'b0;
        chk("empty_valid", 32'(alloc_valid), 32'd0);
        chk("empty_count", 32'(free_count),  32'd0);
        chk("empty_done",  32'(done_flags),  32'h1F);

        alloc_ready = 1'b1;
        step();
        alloc_ready = 1'b0;
        chk("ign_valid", 32'(alloc_valid), 32'd0);
        chk("ign_count", 32'(free_count),  32'd0);
        chk("ign_done",  32'(done_flags),  32'h1F);

        // Free into empty list: visible only after the edge.
        free_valid = 1'b1;
        free_tag   = 5'd2;
        #1;
        chk("nobyp_valid", 32'(alloc_valid), 32'd0);
        step();
        free_valid = 1'b0;
        chk("free2_valid", 32'(alloc_valid), 32'd1);
        chk("free2_tag",   32'(alloc_tag),   32'd2);
        chk("free2_count", 32'(free_count),  32'd1);
        chk("free2_done",  32'(done_flags),  32'h1F);

        free_valid = 1'b1;
        free_tag   = 5'd5;
        step();
        free_valid  = 1'b0;
        alloc_ready = 1'b1;
        step();
        chk("a2_done", 32'(done_flags), 32'h1B);
        chk("a2_tag",  32'(alloc_tag),  32'd5);
        step();
        alloc_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("t5_pending", 32'(done_flags[5]), 32'd0);
            if (k == 3) begin
                cmpl_valid = 1'b1;
                cmpl_tag   = 5'd5;
            end
            step();
        end
        cmpl_valid = 1'b0;
        chk("t5_done",  32'(done_flags), 32'h3B);
        chk("t5_count", 32'(free_count), 32'd0);

        // Refill with 10 tags, then alloc+free every cycle.
        for (int t = 5; t < 15; t++) begin
            free_valid = 1'b1;
            free_tag   = 5'(t);
            step();
            list_q.push_back(5'(t));
        end
        free_valid = 1'b0;
        chk("refill_count", 32'(free_count), 32'd10);
        for (int t = 0; t < 30; t++) begin
            if (t < 5 || t >= 15) out_q.push_back(5'(t));
        end
        exp_done = 30'h3B;

        for (int c = 0; c < 100; c++) begin
            hd = list_q[0];
            chk("loop_tag", 32'(alloc_tag), 32'(hd));
            idx = $urandom_range(0, out_q.size() - 1);
            ft  = out_q[idx];
            out_q.delete(idx);
            alloc_ready = 1'b1;
            free_valid  = 1'b1;
            free_tag    = ft;
            cmpl_valid  = 1'b1;
            cmpl_tag    = ft;
            step();
            void'(list_q.pop_front());
            out_q.push_back(hd);
            list_q.push_back(ft);
            exp_done[ft] = 1'b1;
            exp_done[hd] = 1'b0;
            chk("loop_count", 32'(free_count), 32'd10);
        end
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        cmpl_valid  = 1'b0;
        chk("loop_done", 32'(done_flags), 32'(exp_done));
        chk("loop_head", 32'(alloc_tag),  32'(list_q[0]));

        // Reset wins over concurrent alloc, free and completion.
        alloc_ready = 1'b1;
        free_valid  = 1'b1;
        free_tag    = out_q[0];
        cmpl_valid  = 1'b1;
        cmpl_tag    = out_q[1];
        rst         = 1'b1;
        step();
        rst         = 1'b0;
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        cmpl_valid  = 1'b0;
        chk_reset("mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_tracker.md
# tag_tracker

Physical-tag allocator and completion scoreboard: the producer of the 30-bit `done_flags` vector consumed by every issue buffer. Hands free tags to the rename stage, clears a tag's done bit on allocation, sets it on a functional-unit completion broadcast, and takes tags back on retire. Sits between rename, the completion bus and the retire logic; its `done_flags` output fans out to all issue buffers.

## Interface
- `TAGS`, 30, number of physical tags; equals `done_flags` width.
- `TAG_W`, 5, tag index width; `2**TAG_W >= TAGS`.
- `ARCH_TAGS`, 5, tags 0..ARCH_TAGS-1 hold initial architectural state (A, X, Y, S, P) and are never in the free list at reset.

- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `alloc_tag`  out  TAG_W  tag at the free-list head.
- `alloc_valid`  out  1  free list non-empty.
- `alloc_ready`  in  1  rename consumes `alloc_tag` this cycle.
- `cmpl_valid`  in  1  completion broadcast valid; always accepted.
- `cmpl_tag`  in  TAG_W  tag whose result was written.
- `free_valid`  in  1  retire returns a tag; always accepted.
- `free_tag`  in  TAG_W  tag returned.
- `free_count`  out  TAG_W+1  tags currently in the free list.
- `done_flags`  out  TAGS  bit i = tag i has a valid result.

## Operation
- Free list: circular FIFO, depth `TAGS`, entries `TAG_W` wide; head pointer, tail pointer, count register (`TAG_W+1` bits). Pointers wrap from `TAGS-1` to 0 (non-power-of-two depth; explicit compare, not bit truncation).
- Reset: FIFO entries 0..TAGS-ARCH_TAGS-1 hold tags ARCH_TAGS..TAGS-1 in ascending order; head=0; tail=TAGS-ARCH_TAGS; count=TAGS-ARCH_TAGS; `done_flags` all ones; `alloc_valid`=1; `alloc_tag`=ARCH_TAGS; `free_count`=TAGS-ARCH_TAGS.
- Allocate (`alloc_valid & alloc_ready`): head advances, count decrements, `done_flags[alloc_tag]` cleared.
- Free (`free_valid`): `free_tag` written at tail, tail advances, count increments. `done_flags` unchanged by free.
- Complete (`cmpl_valid`): `done_flags[cmpl_tag]` set.
- Alloc and free same cycle: both pointers advance, count unchanged. No bypass: a tag freed while the list is empty is not allocatable until the next cycle.
- Complete and allocate of the same tag in one cycle: allocation wins (bit cleared). Illegal by protocol; flagged by assertion.
- Complete and free in one cycle: independent.
- `alloc_ready` while `alloc_valid`=0: ignored, no state change.
- Illegal, assertion-only, state undefined: `free_valid` with count=TAGS; `cmpl_tag` or `free_tag` >= TAGS (ignored, no flag write, no push); freeing a tag already in the list.
- `rst` asserted mid-operation: all state returns to reset values at that edge regardless of concurrent alloc/free/cmpl.

## Timing
- `alloc_tag`, `alloc_valid`, `free_count`, `done_flags`: pure functions of registered state; no combinational path from any input.
- Handshake at edge N: `done_flags[tag]`=0 and next head tag visible from N+1.
- Completion at edge N: `done_flags[cmpl_tag]`=1 from N+1; an issue buffer may issue a dependent op in cycle N+1 at earliest.
- Free at edge N: tag counted and allocatable (if at head) from N+1.
- Sustained throughput: one alloc, one free, one completion per cycle.

## Structure
- Shared package/header: `TAGS`, `TAG_W`, `ARCH_TAGS` defines (same source as the `done_flags` width used by issue buffers and `RENAMED_OP_SZ`).
- One natural sub-module: `tag_fifo` (circular FIFO with non-power-of-two depth, reset-time preload, count output); scoreboard bits live in `tag_tracker`.

## Test plan
- Reset, hold `alloc_ready`=0 -> `alloc_tag`=5, `alloc_valid`=1, `free_count`=25, `done_flags`=30'h3FFFFFFF.
- Allocate 25 consecutively -> tags 5..29 in order; after last, `alloc_valid`=0, `free_count`=0, `done_flags`=30'h0000001F.
- From empty: free tag 2 at edge N -> `alloc_valid`=0 during cycle N, 1 with `alloc_tag`=2 at N+1; `done_flags[2]` unchanged.
- Allocate tag 5 at edge N, `cmpl_tag`=5 at edge N+3 -> `done_flags[5]`=0 cycles N+1..N+3, 1 from N+4.
- Simultaneous alloc and free every cycle for 100 cycles with random legal tags -> `free_count` constant; allocated order matches free order after wrap past entry 29.
- Assert `rst` during concurrent alloc+free+cmpl -> next cycle equals reset values exactly.
